lane_unstriper: RTL and testbench

- Receive-side counterpart of the 4-lane striping path: takes one byte stream with a valid qualifier and rebuilds 4-byte groups onto four parallel lanes (out0..out3).
- Issues a single-cycle valid_out per completed group.
- Sits between the serial byte path and the per-lane logic (recirculation / lane FIFOs), so lane data produced upstream can be checked after a round trip.
- Includes realignment, partial-group drop reporting and a group counter for the test bench monitor.

---
 rtl/lane_unstriper.sv | 127 ++++++++++++
 tb/tb_lane_unstriper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_unstriper.sv
// Rebuilds 4-byte groups from a serial byte stream onto four parallel lanes.
// Supports forced realignment to lane 0, with a pulse when a partial group is dropped.
module lane_unstriper #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             align,
    output logic             valid_out,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             partial_drop,
    output logic [CNT_W-1:0] group_count,
    output logic [1:0]       lane_idx
);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

    lane_e            lane_idx_q, lane_idx_d;
    logic [WIDTH-1:0] hold0_q, hold0_d;
    logic [WIDTH-1:0] hold1_q, hold1_d;
    logic [WIDTH-1:0] hold2_q, hold2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             valid_out_q, valid_out_d;
    logic             partial_drop_q, partial_drop_d;
    logic [CNT_W-1:0] group_count_q, group_count_d;

    // The fourth byte goes straight into out3, so only three hold slots exist.
    always_comb begin
        lane_idx_d     = lane_idx_q;
        hold0_d        = hold0_q;
        hold1_d        = hold1_q;
        hold2_d        = hold2_q;
        out0_d         = out0_q;
        out1_d         = out1_q;
        out2_d         = out2_q;
        out3_d         = out3_q;
        valid_out_d    = 1'b0;
        partial_drop_d = 1'b0;
        group_count_d  = group_count_q;

        if (align) begin
            partial_drop_d = (lane_idx_q != LANE0);
            if (valid_in) begin
                hold0_d    = data_in;
                lane_idx_d = LANE1;
            end else begin
                lane_idx_d = LANE0;
            end
        end else if (valid_in) begin
            case (lane_idx_q)
                LANE0: begin
                    hold0_d    = data_in;
                    lane_idx_d = LANE1;
                end
                LANE1: begin
                    hold1_d    = data_in;
                    lane_idx_d = LANE2;
                end
                LANE2: begin
                    hold2_d    = data_in;
                    lane_idx_d = LANE3;
                end
                default: begin
                    out0_d        = hold0_q;
                    out1_d        = hold1_q;
                    out2_d        = hold2_q;
                    out3_d        = data_in;
                    valid_out_d   = 1'b1;
                    group_count_d = group_count_q + 1'b1;
                    lane_idx_d    = LANE0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_idx_q     <= LANE0;
            hold0_q        <= '0;
            hold1_q        <= '0;
            hold2_q        <= '0;
            out0_q         <= '0;
            out1_q         <= '0;
            out2_q         <= '0;
            out3_q         <= '0;
            valid_out_q    <= 1'b0;
            partial_drop_q <= 1'b0;
            group_count_q  <= '0;
        end else begin
            lane_idx_q     <= lane_idx_d;
            hold0_q        <= hold0_d;
            hold1_q        <= hold1_d;
            hold2_q        <= hold2_d;
            out0_q         <= out0_d;
            out1_q         <= out1_d;
            out2_q         <= out2_d;
            out3_q         <= out3_d;
            valid_out_q    <= valid_out_d;
            partial_drop_q <= partial_drop_d;
            group_count_q  <= group_count_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign partial_drop = partial_drop_q;
    assign out0         = out0_q;
    assign out1         = out1_q;
    assign out2         = out2_q;
    assign out3         = out3_q;
    assign group_count  = group_count_q;
    assign lane_idx     = lane_idx_q;

endmodule

// File: tb/tb_lane_unstriper.sv
// Bench for lane_unstriper: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lane_unstriper;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       align;
    logic       valid_out;
    logic [7:0] out0, out1, out2, out3;
    logic       partial_drop;
    logic [7:0] group_count;
    logic [1:0] lane_idx;

    int assertions = 0;
    int failures   = 0;
    bit check_en   = 0;

    // Reference model state: bytes of the group under construction, plus expected outputs.
    logic [7:0] pending[$];
    logic [7:0] exp_out[4];
    logic       exp_valid = 0;
    logic       exp_drop  = 0;
    logic [7:0] exp_count = 0;

    lane_unstriper #(.WIDTH(8), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .align        (align),
        .valid_out    (valid_out),
        .out0         (out0),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .partial_drop (partial_drop),
        .group_count  (group_count),
        .lane_idx     (lane_idx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic apply_stimulus(input logic r, input logic v, input logic a, input logic [7:0] d);
        reset    = r;
        valid_in = v;
        align    = a;
        data_in  = d;
        @(negedge clk);
    endtask

    task automatic check_group(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cnt);
        check_output({name, "_valid"}, {31'd0, valid_out}, 32'd1);
        check_output({name, "_out0"}, {24'd0, out0}, {24'd0, b0});
        check_output({name, "_out1"}, {24'd0, out1}, {24'd0, b1});
        check_output({name, "_out2"}, {24'd0, out2}, {24'd0, b2});
        check_output({name, "_out3"}, {24'd0, out3}, {24'd0, b3});
        check_output({name, "_count"}, {24'd0, group_count}, {24'd0, cnt});
    endtask

    // The model works from the group-building rules directly: collect bytes, emit on the fourth.
    always @(posedge clk) begin
        if (reset) begin
            pending.delete();
            for (int i = 0; i < 4; i++) exp_out[i] = 8'h00;
            exp_valid = 0;
            exp_drop  = 0;
            exp_count = 0;
        end else begin
            exp_valid = 0;
            exp_drop  = 0;
            if (align) begin
                exp_drop = (pending.size() != 0);
                pending.delete();
                if (valid_in) pending.push_back(data_in);
            end else if (valid_in) begin
                pending.push_back(data_in);
                if (pending.size() == 4) begin
                    for (int i = 0; i < 4; i++) exp_out[i] = pending[i];
                    exp_valid = 1;
                    exp_count = exp_count + 8'd1;
                    pending.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("cmp_valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
            check_output("cmp_partial_drop", {31'd0, partial_drop}, {31'd0, exp_drop});
            check_output("cmp_out0", {24'd0, out0}, {24'd0, exp_out[0]});
            check_output("cmp_out1", {24'd0, out1}, {24'd0, exp_out[1]});
            check_output("cmp_out2", {24'd0, out2}, {24'd0, exp_out[2]});
            check_output("cmp_out3", {24'd0, out3}, {24'd0, exp_out[3]});
            check_output("cmp_group_count", {24'd0, group_count}, {24'd0, exp_count});
            check_output("cmp_lane_idx", {30'd0, lane_idx}, pending.size());
        end
    end

    initial begin
        reset    = 1;
        valid_in = 1;
        align    = 0;
        data_in  = 8'hAA;
        @(negedge clk);

        // Reset held two cycles while junk is offered on the byte path.
        apply_stimulus(1, 1, 0, 8'hAA);
        check_en = 1;
        apply_stimulus(1, 1, 0, 8'hAA);
        check_output("rst_valid", {31'd0, valid_out}, 32'd0);
        check_output("rst_drop", {31'd0, partial_drop}, 32'd0);
        check_output("rst_out0", {24'd0, out0}, 32'd0);
        check_output("rst_out3", {24'd0, out3}, 32'd0);
        check_output("rst_count", {24'd0, group_count}, 32'd0);
        check_output("rst_lane", {30'd0, lane_idx}, 32'd0);

        // Continuous full-rate stream 0x01..0x08.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(0, 1, 0, 8'(i));
            if (i == 4) check_group("full_g1", 8'h01, 8'h02, 8'h03, 8'h04, 8'd1);
            if (i == 5) begin
                check_output("full_gap_valid", {31'd0, valid_out}, 32'd0);
                check_output("full_hold_out0", {24'd0, out0}, 32'h01);
            end
            if (i == 8) check_group("full_g2", 8'h05, 8'h06, 8'h07, 8'h08, 8'd2);
        end

        // Alternating valid: only the odd bytes are taken.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, i[0], 0, 8'(i));
            if (i == 7)  check_group("alt_g1", 8'h01, 8'h03, 8'h05, 8'h07, 8'd3);
            if (i == 15) check_group("alt_g2", 8'h09, 8'h0B, 8'h0D, 8'h0F, 8'd4);
        end

        // Realign mid-group with a byte arriving on the same cycle.
        apply_stimulus(0, 1, 0, 8'h10);
        apply_stimulus(0, 1, 0, 8'h11);
        apply_stimulus(0, 1, 1, 8'h20);
        check_output("align_drop", {31'd0, partial_drop}, 32'd1);
        check_output("align_lane", {30'd0, lane_idx}, 32'd1);
        apply_stimulus(0, 1, 0, 8'h21);
        check_output("align_drop_clear", {31'd0, partial_drop}, 32'd0);
        apply_stimulus(0, 1, 0, 8'h22);
        apply_stimulus(0, 1, 0, 8'h23);
        check_group("align_g", 8'h20, 8'h21, 8'h22, 8'h23, 8'd5);

        // Align while empty gives no pulse.
        apply_stimulus(0, 0, 1, 8'h00);
        check_output("align_empty_drop", {31'd0, partial_drop}, 32'd0);

        // Align on the fourth byte: align wins, no group.
        apply_stimulus(0, 1, 0, 8'h50);
        apply_stimulus(0, 1, 0, 8'h51);
        apply_stimulus(0, 1, 0, 8'h52);
        apply_stimulus(0, 1, 1, 8'h53);
        check_output("align4_valid", {31'd0, valid_out}, 32'd0);
        check_output("align4_drop", {31'd0, partial_drop}, 32'd1);
        check_output("align4_count", {24'd0, group_count}, 32'd5);
        check_output("align4_lane", {30'd0, lane_idx}, 32'd1);

        // Reset mid-group discards silently.
        apply_stimulus(0, 1, 0, 8'h40);
        apply_stimulus(0, 1, 0, 8'h41);
        apply_stimulus(1, 0, 0, 8'h00);
        check_output("midrst_drop", {31'd0, partial_drop}, 32'd0);
        check_output("midrst_lane", {30'd0, lane_idx}, 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 8'(8'h30 + i));
        check_group("midrst_g", 8'h30, 8'h31, 8'h32, 8'h33, 8'd1);
        check_output("midrst_no_drop", {31'd0, partial_drop}, 32'd0);

        // 256 groups at full rate wrap the counter back to zero.
        apply_stimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 1024; i++) begin
            apply_stimulus(0, 1, 0, 8'(i));
            if (i == 1019) check_output("wrap_255", {24'd0, group_count}, 32'd255);
        end
        check_output("wrap_valid", {31'd0, valid_out}, 32'd1);
        check_output("wrap_zero", {24'd0, group_count}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 299) == 0),
                           ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 19) == 0),
                           8'($urandom));
        end

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
